// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the memory-stage load/store unit:
//               funct3 access-type codes, FSM state encoding, and helpers
//               for store byte-lane enables and store-data replication.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // funct3 access-type codes (BU/HU exist for loads only)
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Byte-lane mask used by every load and by word stores
    localparam logic [3:0] BE_ALL = 4'b1111;

    // Two-state transaction FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Byte-lane enables for a store of the given size at the given offset.
    // Only meaningful for legal (aligned) stores.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        logic [3:0] be;
        be = BE_ALL;
        case (funct3)
            LS_B:    be = 4'b0001 << offset;
            LS_H:    be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = BE_ALL;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes so that whichever lanes
    // are enabled see the correct bytes without a barrel shifter.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] data;
        data = wdata;
        case (funct3)
            LS_B:    data = {4{wdata[7:0]}};
            LS_H:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Bundle of the pipeline request, data-memory and write-back
//               signals of the load/store unit.
//   slave  modport : the load/store unit itself
//   master modport : the environment (EX/MEM stage, data memory, WB stage)
//   Request  : req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd
//   Pipeline : stall
//   Memory   : mem_req, mem_we, mem_addr, mem_be, mem_wdata,
//              mem_ready, mem_rdata
//   WB       : wb_valid, wb_rd, wb_data, access_err
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              access_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rdata,
        output stall,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_data, access_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rdata,
        input  stall,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_data, access_err
    );

endinterface : mem_access_unit_if
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load aligner and access legality check.
//   rdata  in  32  read word from data memory
//   offset in  2   byte offset within the word (addr[1:0])
//   funct3 in  3   access type
//   we     in  1   1 = store (only affects legality)
//   data   out 32  shifted and sign/zero-extended load data
//   legal  out 1   access is aligned and its funct3 is valid for its type
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  offset,
    input  wire logic [2:0]  funct3,
    input  wire logic        we,
    output logic      [31:0] data,
    output logic             legal
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/halfword down to bit 0
    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        case (funct3)
            LS_B:    data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            LS_H:    data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LS_W:    data = rdata;
            LS_BU:   data = {24'h000000, w_shifted[7:0]};
            LS_HU:   data = {16'h0000,   w_shifted[15:0]};
            default: data = rdata;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (funct3)
            LS_B:    legal = 1'b1;
            LS_H:    legal = ~offset[0];
            LS_W:    legal = (offset == 2'b00);
            LS_BU:   legal = ~we;
            LS_HU:   legal = ~we & ~offset[0];
            default: legal = 1'b0;
        endcase
    end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store unit. Accepts one load or store from
//               EX/MEM, issues a single valid/ready transaction to data
//               memory with byte-lane enables and lane-replicated store data,
//               returns extended load data to write-back, and stalls the
//               pipeline while the transaction is outstanding.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of mem_access_unit_if (request, memory, WB)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_access_unit_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_next;

    logic              w_accept;
    logic              w_reject;
    logic              w_complete;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_access_err;

    // Request fields needed after the accept cycle
    logic [1:0]        r_offset;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;

    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [1:0]        w_sel_offset;
    logic [2:0]        w_sel_funct3;
    logic              w_sel_we;
    logic [31:0]       w_load_data;
    logic              w_legal;

    // ------------------------------------------------------------------------
    // The aligner is shared: in IDLE it judges the incoming request, in WAIT
    // it extends the returning read word using the latched access type.
    // ------------------------------------------------------------------------
    assign w_sel_offset = (r_state == ST_WAIT) ? r_offset : bus.req_addr[1:0];
    assign w_sel_funct3 = (r_state == ST_WAIT) ? r_funct3 : bus.req_funct3;
    assign w_sel_we     = (r_state == ST_WAIT) ? r_mem_we : bus.req_we;

    mem_load_align u_load_align (
        .rdata  (bus.mem_rdata),
        .offset (w_sel_offset),
        .funct3 (w_sel_funct3),
        .we     (w_sel_we),
        .data   (w_load_data),
        .legal  (w_legal)
    );

    // Lane generation for the incoming request; loads read the full word
    always_comb begin
        w_be    = BE_ALL;
        w_wdata = 32'h0000_0000;
        if (bus.req_we) begin
            w_be    = store_be(bus.req_funct3, bus.req_addr[1:0]);
            w_wdata = store_data(bus.req_funct3, bus.req_wdata);
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // mem_ready is deliberately ignored here
                if (bus.req_valid) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_WAIT;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs. Memory outputs are loaded on accept and held
    // untouched through WAIT; only mem_req drops on completion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'h0000_0000;
            r_access_err <= 1'b0;
            r_offset     <= 2'b00;
            r_funct3     <= 3'b000;
            r_rd         <= 5'd0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_access_err <= w_reject;

            if (w_accept) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.req_we;
                r_mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_offset    <= bus.req_addr[1:0];
                r_funct3    <= bus.req_funct3;
                r_rd        <= bus.req_rd;
            end

            if (w_complete) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_load_data;
                    r_wb_rd    <= r_rd;
                end
            end
        end
    end

    // Stall covers the accept cycle and every WAIT cycle without mem_ready;
    // gated by rst_n so the pipeline is never frozen while held in reset.
    assign bus.stall = rst_n & (w_accept | ((r_state == ST_WAIT) & ~bus.mem_ready));

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.wb_data    = r_wb_data;
    assign bus.access_err = r_access_err;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
    endtask

    logic        ill_we  [4];
    logic [2:0]  ill_f3  [4];
    logic [31:0] ill_adr [4];

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
        chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,            32'd0);
        chk("rst_mem_be",     {28'd0, bus.mem_be},     32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
        chk("rst_wb_valid",   {31'd0, bus.wb_valid},   32'd0);
        chk("rst_wb_rd",      {27'd0, bus.wb_rd},      32'd0);
        chk("rst_wb_data",    bus.wb_data,             32'd0);
        chk("rst_access_err", {31'd0, bus.access_err}, 32'd0);
        drive(1'b1, 3'b010, 32'h100, 32'h1, 5'd0);
        #1 chk("stall_in_reset", {31'd0, bus.stall}, 32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // ---------------- SW 0x100, zero-wait ----------------
        drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        #1 chk("sw_stall_accept", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("sw_mem_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("sw_mem_we",    {31'd0, bus.mem_we},  32'd1);
        chk("sw_mem_addr",  bus.mem_addr,         32'h100);
        chk("sw_mem_be",    {28'd0, bus.mem_be},  32'hF);
        chk("sw_mem_wdata", bus.mem_wdata,        32'hDEADBEEF);
        bus.mem_ready = 1'b1;
        #1 chk("sw_stall_ready", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        chk("sw_done_req", {31'd0, bus.mem_req},  32'd0);
        chk("sw_no_wb",    {31'd0, bus.wb_valid}, 32'd0);
        #1 chk("sw_stall_idle", {31'd0, bus.stall}, 32'd0);

        // ---------------- SB 0x103 ----------------
        drive(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0);
        tick();
        chk("sb_mem_addr",  bus.mem_addr,        32'h100);
        chk("sb_mem_be",    {28'd0, bus.mem_be}, 32'h8);
        chk("sb_mem_wdata", bus.mem_wdata,       32'hA5A5A5A5);
        bus.mem_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;

        // ---------------- SH 0x102 ----------------
        drive(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 5'd0);
        tick();
        chk("sh_mem_be",    {28'd0, bus.mem_be}, 32'hC);
        chk("sh_mem_wdata", bus.mem_wdata,       32'h12341234);
        bus.mem_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;

        // ---------------- LB / LBU / LH 0x102, back-to-back ----------------
        bus.mem_rdata = 32'h12807F34;
        drive(1'b0, 3'b000, 32'h102, 32'h0, 5'd5);
        tick();
        chk("lb_mem_be", {28'd0, bus.mem_be}, 32'hF);
        chk("lb_mem_we", {31'd0, bus.mem_we}, 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("lb_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("lb_wb_data",  bus.wb_data,           32'hFFFFFF80);
        chk("lb_wb_rd",    {27'd0, bus.wb_rd},    32'd5);
        chk("lb_req_low",  {31'd0, bus.mem_req},  32'd0);
        drive(1'b0, 3'b100, 32'h102, 32'h0, 5'd6);
        #1 chk("lbu_b2b_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("lbu_req",      {31'd0, bus.mem_req},  32'd1);
        chk("lbu_wb_pulse", {31'd0, bus.wb_valid}, 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("lbu_wb_data", bus.wb_data,        32'h00000080);
        chk("lbu_wb_rd",   {27'd0, bus.wb_rd}, 32'd6);
        drive(1'b0, 3'b001, 32'h102, 32'h0, 5'd9);
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        chk("lh_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("lh_wb_data",  bus.wb_data,           32'h00001280);

        // ---------------- LW 0x200 with 3 wait states ----------------
        tick();
        drive(1'b0, 3'b010, 32'h200, 32'h0, 5'd7);
        #1 chk("lw_stall_c0", {31'd0, bus.stall}, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_req",  {31'd0, bus.mem_req},  32'd1);
            chk("lw_wait_addr", bus.mem_addr,          32'h200);
            chk("lw_wait_be",   {28'd0, bus.mem_be},   32'hF);
            chk("lw_wait_we",   {31'd0, bus.mem_we},   32'd0);
            chk("lw_wait_wb",   {31'd0, bus.wb_valid}, 32'd0);
            #1 chk("lw_wait_stall", {31'd0, bus.stall}, 32'd1);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        chk("lw_ready_stall", {31'd0, bus.stall},    32'd0);
        chk("lw_ready_req",   {31'd0, bus.mem_req},  32'd1);
        chk("lw_ready_wb",    {31'd0, bus.wb_valid}, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        chk("lw_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("lw_wb_data",  bus.wb_data,           32'hCAFEF00D);
        chk("lw_wb_rd",    {27'd0, bus.wb_rd},    32'd7);
        chk("lw_req_low",  {31'd0, bus.mem_req},  32'd0);
        tick();
        chk("lw_wb_oneshot", {31'd0, bus.wb_valid}, 32'd0);

        // ---------------- mem_ready in IDLE ignored ----------------
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("idle_ready_wb",  {31'd0, bus.wb_valid}, 32'd0);
        chk("idle_ready_req", {31'd0, bus.mem_req},  32'd0);

        // ---------------- illegal requests ----------------
        ill_we[0] = 1'b0; ill_f3[0] = 3'b010; ill_adr[0] = 32'h101;  // LW misaligned
        ill_we[1] = 1'b1; ill_f3[1] = 3'b001; ill_adr[1] = 32'h003;  // SH misaligned
        ill_we[2] = 1'b0; ill_f3[2] = 3'b011; ill_adr[2] = 32'h000;  // bad funct3
        ill_we[3] = 1'b1; ill_f3[3] = 3'b100; ill_adr[3] = 32'h000;  // store as BU
        for (int i = 0; i < 4; i++) begin
            drive(ill_we[i], ill_f3[i], ill_adr[i], 32'h55, 5'd1);
            #1 chk("ill_stall", {31'd0, bus.stall}, 32'd0);
            tick();
            bus.req_valid = 1'b0;
            chk("ill_err",  {31'd0, bus.access_err}, 32'd1);
            chk("ill_req",  {31'd0, bus.mem_req},    32'd0);
            chk("ill_wb",   {31'd0, bus.wb_valid},   32'd0);
            tick();
            chk("ill_err_pulse", {31'd0, bus.access_err}, 32'd0);
        end

        // ---------------- reset during WAIT ----------------
        drive(1'b0, 3'b010, 32'h300, 32'h0, 5'd4);
        tick();
        chk("rw_req_before", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_req_async", {31'd0, bus.mem_req}, 32'd0);
        chk("rw_stall",     {31'd0, bus.stall},   32'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("rw_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rw_post_req",  {31'd0, bus.mem_req},    32'd0);
        chk("rw_post_addr", bus.mem_addr,            32'd0);
        chk("rw_post_wb",   {31'd0, bus.wb_valid},   32'd0);
        chk("rw_post_err",  {31'd0, bus.access_err}, 32'd0);
        drive(1'b0, 3'b010, 32'h40, 32'h0, 5'd3);
        tick();
        chk("rw_lw_addr", bus.mem_addr, 32'h40);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11223344;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        chk("rw_lw_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("rw_lw_data",  bus.wb_data,           32'h11223344);
        chk("rw_lw_rd",    {27'd0, bus.wb_rd},    32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
